pipeline_sequencer: RTL

PIPELINE_SEQUENCER -- requirements
Module: pipeline_sequencer

---
 rtl/pipeline_sequencer.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/pipeline_sequencer.sv
// Five-stage pipeline control: stall/flush arbitration, per-stage valid and tag
// tracking, halt drain and retire/stall statistics.
module pipeline_sequencer #(
    parameter int unsigned TAG_MAX = 71,
    parameter int unsigned TAG_W   = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mem_busy,
    input  logic             ld_use,
    input  logic             br_taken,
    input  logic             halt_id,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             ex_mem_en,
    output logic             if_flush,
    output logic             id_flush,
    output logic             v_if,
    output logic             v_id,
    output logic             v_ex,
    output logic             v_mem,
    output logic             v_wb,
    output logic [TAG_W-1:0] tag_if,
    output logic [TAG_W-1:0] tag_id,
    output logic [TAG_W-1:0] tag_ex,
    output logic [TAG_W-1:0] tag_mem,
    output logic [TAG_W-1:0] tag_wb,
    output logic             retire,
    output logic [TAG_W-1:0] retire_tag,
    output logic [15:0]      retired_cnt,
    output logic [15:0]      stall_cnt,
    output logic             done
);

    typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

    state_t state_q, state_d;

    logic             vi_q, vd_q, ve_q, vm_q, vw_q;
    logic [TAG_W-1:0] ti_q, td_q, te_q, tm_q, tw_q, halt_tag_q;
    logic [15:0]      ret_q, stall_q;

    logic stall_busy, stall_ld, do_halt, do_br;
    logic pc_en_c, if_id_c, id_ex_c, ex_mem_c, if_flush_c, id_flush_c;
    logic [TAG_W-1:0] ti_next;

    assign ti_next = (ti_q == TAG_W'(TAG_MAX)) ? '0 : ti_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        stall_busy = 1'b0;
        stall_ld   = 1'b0;
        do_halt    = 1'b0;
        do_br      = 1'b0;
        pc_en_c    = 1'b0;
        if_id_c    = 1'b0;
        id_ex_c    = 1'b0;
        ex_mem_c   = 1'b0;
        if_flush_c = 1'b0;
        id_flush_c = 1'b0;
        if (state_q != DONE) begin
            stall_busy = mem_busy;
            stall_ld   = !mem_busy && vd_q && ld_use;
            // Halt outranks a simultaneous branch: nothing younger than HLT may run.
            do_halt    = !mem_busy && !stall_ld && vd_q && halt_id && (state_q == RUN);
            do_br      = !mem_busy && !stall_ld && !do_halt && vd_q && br_taken;
            if (stall_ld) begin
                id_ex_c    = 1'b1;
                ex_mem_c   = 1'b1;
                id_flush_c = 1'b1;
            end else if (!mem_busy) begin
                pc_en_c    = (state_q == RUN) && !do_halt;
                if_id_c    = 1'b1;
                id_ex_c    = 1'b1;
                ex_mem_c   = 1'b1;
                if_flush_c = do_halt || do_br;
            end
            if (do_halt) state_d = DRAIN;
            if ((state_q == DRAIN) && vw_q && (tw_q == halt_tag_q)) state_d = DONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RUN;
            vi_q       <= 1'b1;
            vd_q       <= 1'b0;
            ve_q       <= 1'b0;
            vm_q       <= 1'b0;
            vw_q       <= 1'b0;
            ti_q       <= '0;
            td_q       <= '0;
            te_q       <= '0;
            tm_q       <= '0;
            tw_q       <= '0;
            halt_tag_q <= '0;
            ret_q      <= '0;
            stall_q    <= '0;
        end else begin
            state_q <= state_d;
            vw_q    <= ex_mem_c ? vm_q : 1'b0;
            if (ex_mem_c) begin
                tw_q <= tm_q;
                vm_q <= ve_q;
                tm_q <= te_q;
            end
            if (id_ex_c) begin
                ve_q <= vd_q & ~id_flush_c;
                te_q <= td_q;
            end
            if (if_id_c) begin
                vd_q <= vi_q & ~if_flush_c;
                td_q <= ti_q;
            end
            if (do_halt || state_q == DRAIN) begin
                vi_q <= 1'b0;
            end else if (pc_en_c && vi_q) begin
                ti_q <= ti_next;
            end
            if (do_halt) halt_tag_q <= td_q;
            // Entering DONE overrides the stage moves above.
            if (state_d == DONE) begin
                vi_q <= 1'b0;
                vd_q <= 1'b0;
                ve_q <= 1'b0;
                vm_q <= 1'b0;
                vw_q <= 1'b0;
            end
            if (vw_q && ret_q != '1) ret_q <= ret_q + 1'b1;
            if ((stall_busy || stall_ld) && stall_q != '1) stall_q <= stall_q + 1'b1;
        end
    end

    assign pc_en       = pc_en_c    & ~rst;
    assign if_id_en    = if_id_c    & ~rst;
    assign id_ex_en    = id_ex_c    & ~rst;
    assign ex_mem_en   = ex_mem_c   & ~rst;
    assign if_flush    = if_flush_c & ~rst;
    assign id_flush    = id_flush_c & ~rst;
    assign v_if        = vi_q & ~rst;
    assign v_id        = vd_q & ~rst;
    assign v_ex        = ve_q & ~rst;
    assign v_mem       = vm_q & ~rst;
    assign v_wb        = vw_q & ~rst;
    assign tag_if      = rst ? '0 : ti_q;
    assign tag_id      = rst ? '0 : td_q;
    assign tag_ex      = rst ? '0 : te_q;
    assign tag_mem     = rst ? '0 : tm_q;
    assign tag_wb      = rst ? '0 : tw_q;
    assign retire      = v_wb;
    assign retire_tag  = tag_wb;
    assign retired_cnt = rst ? '0 : ret_q;
    assign stall_cnt   = rst ? '0 : stall_q;
    assign done        = (state_q == DONE) && !rst;

endmodule
